dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters: the MEM pipeline stage (port P, read/write) and the debug/display scan (port D, read-only).
- Sequences each access through a small FSM and drives dmem's enable, write-enable, address and write data.
- Produces the pipeline stall while a MEM-stage access is outstanding.
- Sits between pipe_mem's memory signals and dmem; D is fed by the board display logic.

Parameters:
- READ_LAT, 2, dmem read latency in cycles from the m_ena cycle to valid m_rdata; legal 1..7.
- MAX_STARVE, 4, consecutive P grants allowed while d_req is waiting before D is forced a grant; legal 1..15.
- AW, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- p_req  in  1  MEM-stage request; held until p_ack.
- p_we  in  1  1 = write, 0 = read; held with p_req.
- p_addr  in  AW  byte address; held with p_req.
- p_wdata  in  32  write data; held with p_req.
- p_ack  out  1  one-cycle completion pulse for P.
- p_rdata  out  32  P read data; valid with p_ack, held until the next P read ack.
- stall  out  1  p_req & ~p_ack (combinational).
- d_req  in  1  debug read request; held until d_ack.
- d_addr  in  AW  debug read address.
- d_ack  out  1  one-cycle completion pulse for D.
- d_rdata  out  32  D read data; valid with d_ack, held until the next D ack.
- m_ena  out  1  dmem enable, registered.
- m_wena  out  1  dmem write enable, registered.
- m_addr  out  AW  dmem address, registered.
- m_wdata  out  32  dmem write data, registered.
- m_rdata  in  32  dmem read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - All outputs = 0.
  - Starvation counter = 0, wait counter = 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, arbitration order:
  - If starve_cnt == MAX_STARVE and d_req: grant D.
  - Else if p_req: grant P.
  - Else if d_req: grant D.
  - Else stay in IDLE.
  - On a grant, register owner, we, addr and wdata into m_*, and go to ACCESS.
- ACCESS (one cycle): m_ena = 1; m_wena = we for P, 0 for D.
  - Write: go to RESP.
  - Read: go to WAIT with wait counter = READ_LAT-1.
  - If READ_LAT == 1: go straight to RESP and capture m_rdata at that edge.
- WAIT: m_ena = 0. Decrement each cycle; at 0, capture m_rdata into the owner's rdata register and go to RESP.
- RESP (one cycle): the owner's ack = 1, then go to IDLE. Requests are ignored in RESP.
- Latency, with request first sampled in IDLE at cycle t:
  - m_ena high at t+1.
  - Write ack at t+2.
  - Read ack at t+2+READ_LAT-1, i.e. t+1+READ_LAT.
  - Earliest next grant is sampled at ack+1.
- Starvation counter:
  - +1 on each P grant while d_req = 1, saturating at MAX_STARVE.
  - Cleared on a D grant, or in any IDLE cycle with d_req = 0.
- Simultaneous p_req and d_req with counter below MAX_STARVE: P wins.
- A requester that drops req before its ack is a protocol violation. The in-flight access still completes and acks.
- rst mid-access, at the next edge:
  - FSM returns to IDLE.
  - m_ena, m_wena, acks, rdata registers and counters are cleared.
  - The pending transaction is discarded with no ack.
- Addresses are passed unmodified. No alignment checking.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, add three output ports:
  - stat_p_grants (16 bits): counts P grants.
  - stat_d_grants (16 bits): counts D grants.
  - stat_stall_cycles (16 bits): counts cycles with stall = 1.
  - All three saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- P write, READ_LAT=2: p_req=1, p_we=1, p_addr=0x10, p_wdata=0xDEADBEEF at cycle 0 -> m_ena=1, m_wena=1, m_addr=0x10, m_wdata=0xDEADBEEF at cycle 1; p_ack at cycle 2; stall=1 in cycles 0-1.
- P read, READ_LAT=2: p_we=0, p_addr=0x10, m_rdata model returns 0xDEADBEEF -> m_ena at cycle 1, p_ack at cycle 3, p_rdata=0xDEADBEEF held afterwards.
- Simultaneous p_req and d_req with counter at 0 -> P served first. D ack follows one full transaction later: 4 cycles after P ack for a read, with READ_LAT=2.
- Starvation, MAX_STARVE=4: d_req held high, P issues back-to-back writes -> exactly 4 P grants, then a D grant, with the counter back to 0.
- Reset mid-read: assert rst during WAIT -> next cycle FSM=IDLE, busy=0, p_ack never pulses, p_rdata=0.
- With DMEM_ARB_STATS_EN: 3 P writes and 1 D read -> stat_p_grants=3, stat_d_grants=1, stat_stall_cycles=6.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between pipe_mem, the debug scan, the arbiter and dmem
//
// Signal groups:
//   P (MEM stage, read/write) : p_req, p_we, p_addr, p_wdata -> p_ack, p_rdata, stall
//   D (debug scan, read-only) : d_req, d_addr                -> d_ack, d_rdata
//   dmem side                 : m_ena, m_wena, m_addr, m_wdata <- m_rdata
//   status                    : busy
// Modports:
//   slave  - the arbiter's view
//   master - the view of everything around the arbiter (requesters and dmem)
interface dmem_arbiter_if #(
    parameter int AW = 32
) ();
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_wdata;
    logic          p_ack;
    logic [31:0]   p_rdata;
    logic          stall;

    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          m_ena;
    logic          m_wena;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    logic          busy;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, d_req, d_addr, m_rdata,
        output p_ack, p_rdata, stall, d_ack, d_rdata,
        output m_ena, m_wena, m_addr, m_wdata, busy
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, d_req, d_addr, m_rdata,
        input  p_ack, p_rdata, stall, d_ack, d_rdata,
        input  m_ena, m_wena, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing dmem between the MEM stage and the debug scan
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - dmem_arbiter_if.slave: P request/ack, D request/ack, dmem drive, busy
// Optional (macro DMEM_ARB_STATS_EN):
//   stat_p_grants, stat_d_grants, stat_stall_cycles - 16-bit saturating counters
// Parameters:
//   READ_LAT   (1..7)  dmem read latency, m_ena cycle to captured m_rdata
//   MAX_STARVE (1..15) P grants allowed while D waits before D is forced in
//   AW                 address width
module dmem_arbiter #(
    parameter int READ_LAT   = 2,
    parameter int MAX_STARVE = 4,
    parameter int AW         = 32
) (
    input  logic clk,
    input  logic rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_p_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_INIT  = 3'(READ_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;         // 0 = P, 1 = D
    logic [2:0]    wait_q, wait_d;
    logic [3:0]    starve_q, starve_d;
    logic [31:0]   p_rdata_q, p_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          m_ena_q, m_ena_d;
    logic          m_wena_q, m_wena_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          grant_p, grant_d, capture;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wait_d    = wait_q;
        starve_d  = starve_q;
        p_rdata_d = p_rdata_q;
        d_rdata_d = d_rdata_q;
        m_ena_d   = 1'b0;
        m_wena_d  = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        grant_p   = 1'b0;
        grant_d   = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.d_req) starve_d = 4'd0;
                if (bus.d_req && starve_q == STARVE_MAX) grant_d = 1'b1;
                else if (bus.p_req)                      grant_p = 1'b1;
                else if (bus.d_req)                      grant_d = 1'b1;

                if (grant_p) begin
                    owner_d   = 1'b0;
                    m_ena_d   = 1'b1;
                    m_wena_d  = bus.p_we;
                    m_addr_d  = bus.p_addr;
                    m_wdata_d = bus.p_wdata;
                    state_d   = ACCESS;
                    if (bus.d_req && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
                end else if (grant_d) begin
                    owner_d   = 1'b1;
                    m_ena_d   = 1'b1;
                    m_addr_d  = bus.d_addr;
                    state_d   = ACCESS;
                    starve_d  = 4'd0;
                end
            end
            ACCESS: begin
                if (m_wena_q) begin
                    state_d = RESP;
                end else if (READ_LAT == 1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter reaching zero at this edge is the capture point.
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (owner_q) d_rdata_d = bus.m_rdata;
            else         p_rdata_d = bus.m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            wait_q    <= 3'd0;
            starve_q  <= 4'd0;
            p_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            m_ena_q   <= 1'b0;
            m_wena_q  <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
            p_rdata_q <= p_rdata_d;
            d_rdata_q <= d_rdata_d;
            m_ena_q   <= m_ena_d;
            m_wena_q  <= m_wena_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    logic p_ack, stall;
    assign p_ack = (state_q == RESP) && !owner_q;
    assign stall = bus.p_req && !p_ack;

    assign bus.p_ack   = p_ack;
    assign bus.d_ack   = (state_q == RESP) && owner_q;
    assign bus.stall   = stall;
    assign bus.p_rdata = p_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_ena   = m_ena_q;
    assign bus.m_wena  = m_wena_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.busy    = (state_q != IDLE);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_p_q, stat_p_d;
    logic [15:0] stat_d_q, stat_d_d;
    logic [15:0] stat_s_q, stat_s_d;

    always_comb begin
        stat_p_d = stat_p_q;
        stat_d_d = stat_d_q;
        stat_s_d = stat_s_q;
        if (grant_p && stat_p_q != 16'hFFFF) stat_p_d = stat_p_q + 16'd1;
        if (grant_d && stat_d_q != 16'hFFFF) stat_d_d = stat_d_q + 16'd1;
        if (stall   && stat_s_q != 16'hFFFF) stat_s_d = stat_s_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_p_q <= 16'd0;
            stat_d_q <= 16'd0;
            stat_s_q <= 16'd0;
        end else begin
            stat_p_q <= stat_p_d;
            stat_d_q <= stat_d_d;
            stat_s_q <= stat_s_d;
        end
    end

    assign stat_p_grants     = stat_p_q;
    assign stat_d_grants     = stat_d_q;
    assign stat_stall_cycles = stat_s_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    integer errors = 0;
    integer checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_p_grants, stat_d_grants, stat_stall_cycles;
`endif

    dmem_arbiter #(.READ_LAT(2), .MAX_STARVE(4), .AW(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_p_grants(stat_p_grants),
        .stat_d_grants(stat_d_grants),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    // dmem model: 64 words, combinational read of the registered address.
    logic [31:0] mem [0:63];
    assign bus.m_rdata = mem[bus.m_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[8]  <= 32'h11112222;   // 0x20
            mem[12] <= 32'h33334444;   // 0x30
        end else if (bus.m_ena && bus.m_wena) begin
            mem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 0; bus.d_addr = '0;
        rst = 1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.m_ena !== 1'b0)  begin errors++; $display("FAIL reset_m_ena: got %0b want 0", bus.m_ena); end
        checks++; if (bus.m_wena !== 1'b0) begin errors++; $display("FAIL reset_m_wena: got %0b want 0", bus.m_wena); end
        checks++; if (bus.p_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got p=%0b d=%0b want 0 0", bus.p_ack, bus.d_ack); end
        checks++; if (bus.p_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got p=%h d=%h want 0 0", bus.p_rdata, bus.d_rdata); end
        checks++; if (bus.m_addr !== 32'd0 || bus.m_wdata !== 32'd0) begin errors++; $display("FAIL reset_m_bus: got a=%h d=%h want 0 0", bus.m_addr, bus.m_wdata); end
        tick();
        rst = 0;
    endtask

    task automatic test_p_write();
        // cycle 0
        tick();
        bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h10; bus.p_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wr_stall_c0: got %0b want 1", bus.stall); end
        checks++; if (bus.m_ena !== 1'b0) begin errors++; $display("FAIL wr_m_ena_c0: got %0b want 0", bus.m_ena); end
        // cycle 1
        tick();
        @(negedge clk);
        checks++; if (bus.m_ena !== 1'b1 || bus.m_wena !== 1'b1) begin errors++; $display("FAIL wr_ena_c1: got ena=%0b wena=%0b want 1 1", bus.m_ena, bus.m_wena); end
        checks++; if (bus.m_addr !== 32'h10) begin errors++; $display("FAIL wr_addr_c1: got %h want 00000010", bus.m_addr); end
        checks++; if (bus.m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata_c1: got %h want deadbeef", bus.m_wdata); end
        checks++; if (bus.stall !== 1'b1 || bus.p_ack !== 1'b0) begin errors++; $display("FAIL wr_stall_c1: got stall=%0b ack=%0b want 1 0", bus.stall, bus.p_ack); end
        // cycle 2
        tick();
        @(negedge clk);
        checks++; if (bus.p_ack !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL wr_ack_c2: got ack=%0b stall=%0b want 1 0", bus.p_ack, bus.stall); end
        checks++; if (bus.m_ena !== 1'b0) begin errors++; $display("FAIL wr_m_ena_c2: got %0b want 0", bus.m_ena); end
        // cycle 3
        tick();
        bus.p_req = 0; bus.p_we = 0;
        @(negedge clk);
        checks++; if (bus.p_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_done_c3: got ack=%0b busy=%0b want 0 0", bus.p_ack, bus.busy); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h want deadbeef", mem[4]); end
    endtask

    task automatic test_p_read();
        tick();
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h10; bus.p_wdata = 32'h0;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c0: got %0b want 1", bus.stall); end
        tick();
        @(negedge clk);
        checks++; if (bus.m_ena !== 1'b1 || bus.m_wena !== 1'b0) begin errors++; $display("FAIL rd_ena_c1: got ena=%0b wena=%0b want 1 0", bus.m_ena, bus.m_wena); end
        tick();
        @(negedge clk);
        checks++; if (bus.m_ena !== 1'b0 || bus.p_ack !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rd_wait_c2: got ena=%0b ack=%0b busy=%0b want 0 0 1", bus.m_ena, bus.p_ack, bus.busy); end
        tick();
        @(negedge clk);
        checks++; if (bus.p_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c3: got %0b want 1", bus.p_ack); end
        checks++; if (bus.p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_c3: got %h want deadbeef", bus.p_rdata); end
        tick();
        bus.p_req = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (bus.p_ack !== 1'b0 || bus.p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got ack=%0b data=%h want 0 deadbeef", bus.p_ack, bus.p_rdata); end
    endtask

    task automatic test_simultaneous();
        integer d_early;
        d_early = 0;
        tick();   // cycle 0
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h20;
        bus.d_req = 1; bus.d_addr = 32'h30;
        tick();   // cycle 1
        @(negedge clk);
        checks++; if (bus.m_ena !== 1'b1 || bus.m_addr !== 32'h20) begin errors++; $display("FAIL sim_p_first: got ena=%0b addr=%h want 1 00000020", bus.m_ena, bus.m_addr); end
        tick();   // cycle 2
        tick();   // cycle 3
        @(negedge clk);
        checks++; if (bus.p_ack !== 1'b1 || bus.p_rdata !== 32'h11112222) begin errors++; $display("FAIL sim_p_ack: got ack=%0b data=%h want 1 11112222", bus.p_ack, bus.p_rdata); end
        if (bus.d_ack !== 1'b0) d_early++;
        tick();   // cycle 4
        bus.p_req = 0;
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            if (bus.d_ack !== 1'b0) d_early++;
            if (c == 5) begin
                checks++; if (bus.m_ena !== 1'b1 || bus.m_addr !== 32'h30) begin errors++; $display("FAIL sim_d_grant: got ena=%0b addr=%h want 1 00000030", bus.m_ena, bus.m_addr); end
            end
            tick();
        end
        checks++; if (d_early != 0) begin errors++; $display("FAIL sim_d_early: got %0d early d_ack cycles want 0", d_early); end
        @(negedge clk);   // cycle 7 = P ack + 4
        checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h33334444) begin errors++; $display("FAIL sim_d_ack: got ack=%0b data=%h want 1 33334444", bus.d_ack, bus.d_rdata); end
        tick();
        bus.d_req = 0;
        @(negedge clk);
        checks++; if (bus.d_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sim_done: got ack=%0b busy=%0b want 0 0", bus.d_ack, bus.busy); end
    endtask

    task automatic test_starvation();
        logic is_d [0:9];
        integer n, cyc;
        n = 0; cyc = 0;
        tick();
        bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h40; bus.p_wdata = 32'h55AA55AA;
        bus.d_req = 1; bus.d_addr = 32'h30;
        while (n < 10 && cyc < 150) begin
            @(negedge clk);
            if (bus.m_ena) begin
                is_d[n] = (bus.m_addr == 32'h30);
                n++;
            end
            tick();
            cyc++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL starve_timeout: got %0d grants want 10", n); end
        for (int i = 0; i < 10 && i < n; i++) begin
            checks++;
            if (is_d[i] !== (i == 4 || i == 9)) begin
                errors++; $display("FAIL starve_grant%0d: got is_d=%0b want %0b", i, is_d[i], (i == 4 || i == 9));
            end
        end
        bus.p_req = 0; bus.d_req = 0; bus.p_we = 0;
        for (int k = 0; k < 20 && bus.busy; k++) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_drain: got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_read();
        integer bad_ack;
        bad_ack = 0;
        tick();   // cycle 0
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h20;
        tick();   // cycle 1: ACCESS
        tick();   // cycle 2: WAIT
        rst = 1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.m_ena !== 1'b0) begin errors++; $display("FAIL mid_wait: got busy=%0b ena=%0b want 1 0", bus.busy, bus.m_ena); end
        tick();   // cycle 3
        rst = 0; bus.p_req = 0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.p_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin errors++; $display("FAIL mid_rdata: got p=%h d=%h want 0 0", bus.p_rdata, bus.d_rdata); end
        for (int c = 0; c < 4; c++) begin
            if (bus.p_ack !== 1'b0) bad_ack++;
            tick();
            @(negedge clk);
        end
        checks++; if (bad_ack != 0) begin errors++; $display("FAIL mid_no_ack: got %0d ack cycles want 0", bad_ack); end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        tick();
        rst = 1;
        tick();
        rst = 0;
        for (int w = 0; w < 3; w++) begin
            bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h44; bus.p_wdata = 32'(w);
            tick(); tick(); tick();
            bus.p_req = 0; bus.p_we = 0;
            tick();
        end
        bus.d_req = 1; bus.d_addr = 32'h20;
        tick(); tick(); tick(); tick();
        bus.d_req = 0;
        tick();
        @(negedge clk);
        checks++; if (stat_p_grants !== 16'd3) begin errors++; $display("FAIL stat_p: got %0d want 3", stat_p_grants); end
        checks++; if (stat_d_grants !== 16'd1) begin errors++; $display("FAIL stat_d: got %0d want 1", stat_d_grants); end
        checks++; if (stat_stall_cycles !== 16'd6) begin errors++; $display("FAIL stat_stall: got %0d want 6", stat_stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_p_write();
        test_p_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
